// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared constants and types for the data-memory responder
package dmem_responder_pkg;

    // Upper half of the MMIO window base address
    localparam logic [15:0] MMIO_BASE_HI = 16'h1faf;

    // Register offsets inside the MMIO window (word aligned)
    localparam logic [15:0] MMIO_COUNT   = 16'h0000;
    localparam logic [15:0] MMIO_COMPARE = 16'h0004;
    localparam logic [15:0] MMIO_STATUS  = 16'h0008;
    localparam logic [15:0] MMIO_CONSOLE = 16'h000c;

    // STATUS bit positions
    localparam int STATUS_IRQ_BIT      = 0;
    localparam int STATUS_FULL_BIT     = 1;
    localparam int STATUS_EMPTY_BIT    = 2;
    localparam int STATUS_OVERFLOW_BIT = 3;

    // Packed so that irq lands on bit 0 and overflow on bit 3
    typedef struct packed {
        logic overflow;
        logic empty;
        logic full;
        logic irq;
    } mmio_status_t;

    // Target selected by the current address
    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_COUNT,
        SEL_COMPARE,
        SEL_STATUS,
        SEL_CONSOLE,
        SEL_UNMAPPED
    } dmem_sel_e;

    // STATUS as it appears on the read bus
    function automatic logic [31:0] status_word(input mmio_status_t s);
        return {28'd0, s};
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - core data port plus console stream and timer interrupt
interface dmem_responder_if;
    logic [31:0] dmem_addr;
    logic        memread;
    logic        memwrite;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        cons_valid;
    logic [7:0]  cons_data;
    logic        cons_ready;
    logic        timer_irq;

    // Core / testbench side
    modport master (
        output dmem_addr, memread, memwrite, dmem_wdata, cons_ready,
        input  dmem_rdata, cons_valid, cons_data, timer_irq
    );

    // Responder side
    modport slave (
        input  dmem_addr, memread, memwrite, dmem_wdata, cons_ready,
        output dmem_rdata, cons_valid, cons_data, timer_irq
    );
endinterface

// File: rtl/dmem_responder_console_fifo.sv
// rtl/dmem_responder_console_fifo.sv - console byte FIFO with valid/ready drain side
module console_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    output logic                     o_full,
    output logic                     o_drop,
    input  logic                     i_pop_ready,
    output logic                     o_valid,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    // Pointers carry one extra bit so full and empty are distinguishable
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_pop;
    logic w_push_ok;

    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign o_full    = (o_count == FULL_COUNT);
    assign o_valid   = (o_count != '0);
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];
    assign w_pop     = o_valid && i_pop_ready;
    // A pop frees the head slot in the same edge, so a full FIFO still accepts a push
    assign w_push_ok = i_push && (!o_full || w_pop);
    assign o_drop    = i_push && o_full && !w_pop;

    // Pointer update; reset discards contents by emptying the pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; on full push+pop this overwrites the slot being read out this cycle
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder: word RAM plus timer and console MMIO
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          RAM_WORDS  = 1024,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] MMIO_BASE  = {MMIO_BASE_HI, 16'h0000}
) (
    input  logic            clk,
    input  logic            resetn,
    dmem_responder_if.slave bus
);
    localparam int RAM_AW  = $clog2(RAM_WORDS);
    localparam int FIFO_CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0] r_ram [RAM_WORDS];
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_irq;
    logic        r_overflow;

    logic               w_mmio_hit;
    logic [15:0]        w_offset;
    logic [RAM_AW-1:0]  w_ram_idx;
    dmem_sel_e          w_sel;
    logic               w_wr_ram;
    logic               w_wr_count;
    logic               w_wr_compare;
    logic               w_wr_status;
    logic               w_wr_console;
    logic               w_irq_match;
    logic               w_irq_clear;
    logic               w_ovf_clear;
    logic               w_fifo_full;
    logic               w_fifo_drop;
    logic               w_fifo_valid;
    logic [7:0]         w_fifo_data;
    logic [FIFO_CW-1:0] w_fifo_count;
    mmio_status_t       w_status;
    logic [31:0]        w_rdata;
    logic               w_unused_addr;

    // Byte lane bits are meaningless for word-only access
    assign w_unused_addr = ^bus.dmem_addr[1:0];

    assign w_mmio_hit = (bus.dmem_addr[31:16] == MMIO_BASE[31:16]);
    assign w_offset   = {bus.dmem_addr[15:2], 2'b00};
    // Upper address bits above the RAM index alias onto the same words
    assign w_ram_idx  = bus.dmem_addr[RAM_AW+1:2];

    // Address decode into a single target
    always_comb begin
        w_sel = SEL_RAM;
        if (w_mmio_hit) begin
            case (w_offset)
                MMIO_COUNT:   w_sel = SEL_COUNT;
                MMIO_COMPARE: w_sel = SEL_COMPARE;
                MMIO_STATUS:  w_sel = SEL_STATUS;
                MMIO_CONSOLE: w_sel = SEL_CONSOLE;
                default:      w_sel = SEL_UNMAPPED;
            endcase
        end
    end

    assign w_wr_ram     = bus.memwrite && (w_sel == SEL_RAM);
    assign w_wr_count   = bus.memwrite && (w_sel == SEL_COUNT);
    assign w_wr_compare = bus.memwrite && (w_sel == SEL_COMPARE);
    assign w_wr_status  = bus.memwrite && (w_sel == SEL_STATUS);
    assign w_wr_console = bus.memwrite && (w_sel == SEL_CONSOLE);

    // Match uses the value COUNT holds before this edge's increment
    assign w_irq_match = (r_count == r_compare);
    assign w_irq_clear = w_wr_compare || (w_wr_status && bus.dmem_wdata[STATUS_IRQ_BIT]);
    assign w_ovf_clear = w_wr_status && bus.dmem_wdata[STATUS_OVERFLOW_BIT];

    assign w_status.irq      = r_irq;
    assign w_status.full     = w_fifo_full;
    assign w_status.empty    = !w_fifo_valid;
    assign w_status.overflow = r_overflow;

    console_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_console_fifo (
        .clk         (clk),
        .rst_n       (resetn),
        .i_push      (w_wr_console),
        .i_push_data (bus.dmem_wdata[7:0]),
        .o_full      (w_fifo_full),
        .o_drop      (w_fifo_drop),
        .i_pop_ready (bus.cons_ready),
        .o_valid     (w_fifo_valid),
        .o_data      (w_fifo_data),
        .o_count     (w_fifo_count)
    );

    // Zero-latency read mux; a same-cycle write is not visible until after the edge
    always_comb begin
        w_rdata = '0;
        if (bus.memread) begin
            case (w_sel)
                SEL_RAM:     w_rdata = r_ram[w_ram_idx];
                SEL_COUNT:   w_rdata = r_count;
                SEL_COMPARE: w_rdata = r_compare;
                SEL_STATUS:  w_rdata = status_word(w_status);
                SEL_CONSOLE: w_rdata = 32'(w_fifo_count);
                default:     w_rdata = '0;
            endcase
        end
    end

    // RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (w_wr_ram) r_ram[w_ram_idx] <= bus.dmem_wdata;
    end

    // Free-running counter; a software load replaces that cycle's increment
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)         r_count <= '0;
        else if (w_wr_count) r_count <= bus.dmem_wdata;
        else                 r_count <= r_count + 32'd1;
    end

    // Compare register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)           r_compare <= 32'hffff_ffff;
        else if (w_wr_compare) r_compare <= bus.dmem_wdata;
    end

    // Sticky STATUS bits; a same-cycle set wins over any clear
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_irq      <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_irq_match)      r_irq <= 1'b1;
            else if (w_irq_clear) r_irq <= 1'b0;
            if (w_fifo_drop)      r_overflow <= 1'b1;
            else if (w_ovf_clear) r_overflow <= 1'b0;
        end
    end

    assign bus.dmem_rdata = w_rdata;
    assign bus.cons_valid = w_fifo_valid;
    assign bus.cons_data  = w_fifo_data;
    assign bus.timer_irq  = r_irq;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder against a queue/array model
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    dmem_responder_if bus();

    dmem_responder #(
        .RAM_WORDS  (1024),
        .FIFO_DEPTH (DEPTH),
        .MMIO_BASE  (32'h1faf_0000)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        cons_valid;
        logic [7:0]  cons_data;
        logic        irq;
        string       name;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] cons_q[$];
    int         n_checks = 0;
    int         n_err = 0;

    // Reference model state
    logic [31:0] m_ram [int];
    logic [7:0]  fq[$];
    logic [31:0] m_cnt_base;
    longint      m_cnt_cyc;
    longint      m_cyc = 0;
    logic [31:0] m_compare;
    logic        m_irq;
    logic        m_ovf;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // COUNT is the load value plus the number of clocks since it was loaded
    function automatic logic [31:0] count_now();
        return m_cnt_base + 32'(m_cyc - m_cnt_cyc);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [15:0] off;
        off = {a[15:2], 2'b00};
        if (a[31:16] != 16'h1faf) begin
            if (m_ram.exists(int'(a[11:2]))) return m_ram[int'(a[11:2])];
            return 32'hxxxx_xxxx;
        end
        if (off == 16'h0000) return count_now();
        if (off == 16'h0004) return m_compare;
        if (off == 16'h0008) return {28'd0, m_ovf, fq.size() == 0, fq.size() == DEPTH, m_irq};
        if (off == 16'h000c) return 32'(fq.size());
        return 32'd0;
    endfunction

    task automatic model_reset();
        m_cnt_base = 32'd0;
        m_cnt_cyc  = m_cyc;
        m_compare  = 32'hffff_ffff;
        m_irq      = 1'b0;
        m_ovf      = 1'b0;
        fq.delete();
        cons_q.delete();
    endtask

    task automatic model_step(input bit wr, input logic [31:0] a, input logic [31:0] wd, input bit rdy);
        logic [15:0] off;
        bit mmio, popped, full, irq_set, irq_clr, ovf_clr, drop;
        off     = {a[15:2], 2'b00};
        mmio    = (a[31:16] == 16'h1faf);
        popped  = rdy && (fq.size() > 0);
        full    = (fq.size() == DEPTH);
        irq_set = (count_now() == m_compare);
        irq_clr = 0;
        ovf_clr = 0;
        drop    = 0;
        if (popped) cons_q.push_back(fq.pop_front());
        if (wr && !mmio) m_ram[int'(a[11:2])] = wd;
        if (wr && mmio) begin
            if (off == 16'h0000) begin
                m_cnt_base = wd;
                m_cnt_cyc  = m_cyc + 1;
            end else if (off == 16'h0004) begin
                m_compare = wd;
                irq_clr   = 1;
            end else if (off == 16'h0008) begin
                irq_clr = wd[0];
                ovf_clr = wd[3];
            end else if (off == 16'h000c) begin
                if (!full || popped) fq.push_back(wd[7:0]);
                else drop = 1;
            end
        end
        if (irq_set) m_irq = 1'b1;
        else if (irq_clr) m_irq = 1'b0;
        if (drop) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
        m_cyc++;
    endtask

    // Drive one bus cycle, queue what the DUT must show this cycle, advance the model
    task automatic step_cycle(input bit rd, input bit wr, input logic [31:0] a,
                              input logic [31:0] wd, input bit rdy, input string nm);
        exp_t e;
        bus.memread    = rd;
        bus.memwrite   = wr;
        bus.dmem_addr  = a;
        bus.dmem_wdata = wd;
        bus.cons_ready = rdy;
        e.rdata      = rd ? model_read(a) : 32'd0;
        e.cons_valid = (fq.size() > 0);
        e.cons_data  = (fq.size() > 0) ? fq[0] : 8'd0;
        e.irq        = m_irq;
        e.name       = nm;
        exp_q.push_back(e);
        model_step(wr, a, wd, rdy);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mmio(input logic [15:0] off);
        return {MMIO_BASE_HI, off} | 32'($urandom_range(0, 3));
    endfunction

    function automatic logic [31:0] ram_addr();
        return 32'(($urandom_range(0, 15) << 12) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
    endfunction

    // Monitor: compare every presented cycle, and every accepted console byte
    exp_t me;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            check({me.name, " rdata"}, bus.dmem_rdata, me.rdata);
            check({me.name, " cons_valid"}, 32'(bus.cons_valid), 32'(me.cons_valid));
            check({me.name, " timer_irq"}, 32'(bus.timer_irq), 32'(me.irq));
            if (me.cons_valid) check({me.name, " cons_data"}, 32'(bus.cons_data), 32'(me.cons_data));
        end
        if (resetn && bus.cons_valid && bus.cons_ready) begin
            if (cons_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL console pop: got byte %h expected none", bus.cons_data);
            end else begin
                check("console byte", 32'(bus.cons_data), 32'(cons_q.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        logic [31:0] a;
        logic [31:0] d;
        bit rdy;

        resetn         = 1'b0;
        bus.memread    = 1'b0;
        bus.memwrite   = 1'b0;
        bus.dmem_addr  = 32'd0;
        bus.dmem_wdata = 32'd0;
        bus.cons_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        model_reset();

        // Timer
        step_cycle(1, 1, mmio(MMIO_COMPARE), 32'd5, 0, "cmp5 write");
        repeat (8) step_cycle(0, 0, 32'd0, 32'd0, 0, "timer idle");
        step_cycle(1, 0, mmio(MMIO_STATUS), 32'd0, 0, "status irq");
        step_cycle(0, 1, mmio(MMIO_STATUS), 32'd1, 0, "status w1c");
        step_cycle(1, 0, mmio(MMIO_STATUS), 32'd0, 0, "status cleared");
        step_cycle(0, 1, mmio(MMIO_COMPARE), count_now() + 32'd2, 0, "cmp near");
        repeat (4) step_cycle(0, 0, 32'd0, 32'd0, 0, "irq wait");
        step_cycle(0, 1, mmio(MMIO_COMPARE), 32'd5, 0, "cmp write clears");
        step_cycle(1, 0, mmio(MMIO_COMPARE), 32'd0, 0, "cmp readback");

        // RAM round trip
        step_cycle(0, 1, 32'h0000_0010, 32'hdead_beef, 0, "ram wr");
        step_cycle(1, 0, 32'h0000_0010, 32'd0, 0, "ram rd");
        step_cycle(0, 0, 32'h0000_0010, 32'd0, 0, "ram no memread");
        step_cycle(1, 1, 32'h0000_0010, 32'd1, 0, "ram rd+wr");
        step_cycle(1, 0, 32'h0000_0010, 32'd0, 0, "ram rd new");
        step_cycle(1, 0, 32'h0040_5010, 32'd0, 0, "ram alias");

        // Counter wrap
        step_cycle(0, 1, mmio(MMIO_COUNT), 32'hffff_fffe, 0, "count load");
        step_cycle(1, 0, mmio(MMIO_COUNT), 32'd0, 0, "count fffe");
        step_cycle(1, 0, mmio(MMIO_COUNT), 32'd0, 0, "count ffff");
        step_cycle(1, 0, mmio(MMIO_COUNT), 32'd0, 0, "count wrap");
        step_cycle(0, 1, mmio(MMIO_COMPARE), 32'h8000_0000, 0, "cmp far");
        step_cycle(0, 1, mmio(MMIO_STATUS), 32'h9, 0, "status clr all");

        // FIFO fill, overflow, drain
        for (int i = 0; i < 4; i++) step_cycle(0, 1, mmio(MMIO_CONSOLE), 32'h41 + 32'(i), 0, "push");
        step_cycle(1, 0, mmio(MMIO_STATUS), 32'd0, 0, "status full");
        step_cycle(0, 1, mmio(MMIO_CONSOLE), 32'h45, 0, "push E");
        step_cycle(1, 0, mmio(MMIO_STATUS), 32'd0, 0, "status ovf");
        step_cycle(1, 0, mmio(MMIO_CONSOLE), 32'd0, 0, "occupancy 4");
        repeat (5) step_cycle(0, 0, 32'd0, 32'd0, 1, "drain");
        step_cycle(1, 0, mmio(MMIO_STATUS), 32'd0, 0, "status empty");
        step_cycle(0, 1, mmio(MMIO_STATUS), 32'h8, 0, "ovf clr");

        // Full push + pop
        for (int i = 0; i < 4; i++) step_cycle(0, 1, mmio(MMIO_CONSOLE), 32'h61 + 32'(i), 0, "push2");
        step_cycle(1, 1, mmio(MMIO_CONSOLE), 32'h5a, 1, "push Z pop");
        step_cycle(1, 0, mmio(MMIO_CONSOLE), 32'd0, 0, "occupancy after");
        step_cycle(1, 0, mmio(MMIO_STATUS), 32'd0, 0, "no ovf");
        repeat (5) step_cycle(0, 0, 32'd0, 32'd0, 1, "drain2");

        // Asynchronous reset with data queued and irq pending
        step_cycle(0, 1, mmio(MMIO_CONSOLE), 32'h31, 0, "pre push1");
        step_cycle(0, 1, mmio(MMIO_CONSOLE), 32'h32, 0, "pre push2");
        step_cycle(0, 1, mmio(MMIO_COMPARE), count_now() + 32'd1, 0, "pre cmp");
        repeat (3) step_cycle(0, 0, 32'd0, 32'd0, 0, "pre wait");
        bus.memread    = 1'b1;
        bus.memwrite   = 1'b0;
        bus.dmem_addr  = mmio(MMIO_COUNT);
        bus.cons_ready = 1'b0;
        #2;
        check("pre-reset cons_valid", 32'(bus.cons_valid), 32'(fq.size() > 0));
        check("pre-reset timer_irq", 32'(bus.timer_irq), 32'(m_irq));
        check("pre-reset count", bus.dmem_rdata, count_now());
        resetn = 1'b0;
        #1;
        check("async cons_valid", 32'(bus.cons_valid), 32'd0);
        check("async timer_irq", 32'(bus.timer_irq), 32'd0);
        check("async count", bus.dmem_rdata, 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        model_reset();
        step_cycle(1, 0, mmio(MMIO_COMPARE), 32'd0, 0, "post-reset cmp");
        step_cycle(1, 0, mmio(MMIO_STATUS), 32'd0, 0, "post-reset status");
        step_cycle(1, 0, 32'h0000_0010, 32'd0, 0, "ram kept");

        // Randomized traffic
        for (int w = 0; w < 8; w++) step_cycle(0, 1, 32'(w * 4), $urandom, 0, "ram init");
        for (int i = 0; i < 500; i++) begin
            op  = int'($urandom_range(0, 11));
            d   = $urandom;
            rdy = ($urandom_range(0, 2) == 0);
            case (op)
                0, 1: step_cycle(0, 1, ram_addr(), d, rdy, "rnd ram wr");
                2, 3: step_cycle(1, 0, ram_addr(), d, rdy, "rnd ram rd");
                4:    step_cycle(1, 1, ram_addr(), d, rdy, "rnd ram rw");
                5:    step_cycle($urandom_range(0, 1) == 1, 1, mmio(MMIO_COMPARE),
                                 count_now() + 32'($urandom_range(0, 12)), rdy, "rnd cmp");
                6:    step_cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                                 mmio(MMIO_STATUS), d & 32'hf, rdy, "rnd status");
                7, 8: step_cycle($urandom_range(0, 1) == 1, 1, mmio(MMIO_CONSOLE), d, rdy, "rnd push");
                9: begin
                    a = ($urandom_range(0, 1) == 1) ? mmio(MMIO_CONSOLE) : mmio(MMIO_COUNT);
                    step_cycle(1, 0, a, d, rdy, "rnd mmio rd");
                end
                10:   step_cycle(1, 1, mmio(MMIO_COUNT), m_compare - 32'($urandom_range(0, 6)), rdy, "rnd count");
                default: step_cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                                    mmio(16'($urandom_range(4, 16383) * 4)), d, rdy, "rnd unmapped");
            endcase
        end
        repeat (6) step_cycle(0, 0, 32'd0, 32'd0, 1, "final drain");
        step_cycle(0, 0, 32'd0, 32'd0, 0, "final idle");
        check("scoreboard empty", 32'(exp_q.size()), 32'd0);
        check("console queue empty", 32'(cons_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
